// File: rtl/vga_capture_pkg.sv
// rtl/vga_capture_pkg.sv - shared types and constants for the VGA frame capture block
package vga_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } cap_state_t;

  localparam int ACT_COLS     = 64;
  localparam int ACT_ROWS     = 192;
  localparam int ROW_REPEAT   = 3;
  localparam int PIX_PER_WORD = 6;

  localparam int DEF_H_START     = 52;
  localparam int DEF_V_START     = 36;
  localparam int DEF_LINE_TOTAL  = 528;
  localparam int DEF_FRAME_TOTAL = 628;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/capture_ram.sv
// rtl/capture_ram.sv - simple dual-port capture memory, registered read path (2-cycle latency)
module capture_ram #(
  parameter int AW = 14,
  parameter int DW = 6
) (
  input  logic          clk,
  input  logic          srst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_q;
  logic          rd_v1;

  // Array stays out of reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      rd_v1    <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_v1    <= rd_en;
      rd_valid <= rd_v1;
      if (rd_v1) rd_data <= rd_q;
    end
  end

endmodule

// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - sync lock detector and armed single-frame monochrome capture
module vga_capture
  import vga_capture_pkg::*;
#(
  parameter int H_START     = DEF_H_START,
  parameter int V_START     = DEF_V_START,
  parameter int LINE_TOTAL  = DEF_LINE_TOTAL,
  parameter int FRAME_TOTAL = DEF_FRAME_TOTAL,
  parameter int COLS        = ACT_COLS,
  parameter int ROWS        = ACT_ROWS
) (
  input  logic       clk,
  input  logic       srst_n,
  input  logic       pix_en,
  input  logic       vid_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       cap_arm,
  input  logic       rd_req,
  input  logic [7:0] rd_y,
  input  logic [5:0] rd_x,
  output logic [5:0] rd_data,
  output logic       rd_valid,
  output logic       locked,
  output logic       cap_busy,
  output logic       cap_done,
  output logic       cap_err
);

  localparam logic [9:0] LINE_LEN  = 10'(LINE_TOTAL);
  localparam logic [9:0] FRAME_LEN = 10'(FRAME_TOTAL);
  localparam logic [9:0] H_BEGIN   = 10'(H_START);
  localparam logic [9:0] H_STOP    = 10'(H_START + COLS * PIX_PER_WORD);
  localparam logic [9:0] V_BEGIN   = 10'(V_START);
  localparam logic [9:0] V_FIRST   = 10'(V_START + 1);
  localparam logic [9:0] V_LAST    = 10'(V_START + ROWS * ROW_REPEAT);
  localparam logic [7:0] LAST_ROW  = 8'(ROWS - 1);
  localparam logic [5:0] LAST_COL  = 6'(COLS - 1);
  localparam logic [1:0] LAST_REP  = 2'(ROW_REPEAT - 1);
  localparam logic [2:0] LAST_PIX  = 3'(PIX_PER_WORD - 1);

  logic       hs_r, hs_d, vs_r, vs_d, vid_r;
  logic [9:0] h_pos, v_cnt;
  logic [1:0] good_lines;
  logic       frame_ok;
  logic [1:0] rep;
  logic [7:0] row;
  logic [5:0] col;
  logic [2:0] pix_k;
  logic [4:0] shreg;

  cap_state_t state, state_nx;
  logic       done_nx, set_err, clr_err;

  logic       hfall, vfall, line_bad, frame_bad, sample_px, wr_en, last_write;
  logic [9:0] next_line;

  assign hfall     = pix_en && hs_d && !hs_r;
  assign vfall     = pix_en && vs_d && !vs_r;
  assign line_bad  = hfall && (h_pos != LINE_LEN);
  assign frame_bad = vfall && (v_cnt != FRAME_LEN);
  assign next_line = vfall ? 10'd0 : v_cnt;

  // h_pos is the offset of the pixel in vid_r from the last HSYNC fall; v_cnt is line index + 1
  assign sample_px  = pix_en && (rep == 2'd1) && (v_cnt >= V_FIRST) && (v_cnt <= V_LAST)
                      && (h_pos >= H_BEGIN) && (h_pos < H_STOP);
  assign wr_en      = sample_px && (pix_k == LAST_PIX) && (state == CAPTURE) && locked;
  assign last_write = wr_en && (row == LAST_ROW) && (col == LAST_COL);
  assign cap_busy   = (state == ARMED) || (state == CAPTURE);

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      hs_r <= 1'b0; hs_d <= 1'b0; vs_r <= 1'b0; vs_d <= 1'b0; vid_r <= 1'b0;
      h_pos <= '0; v_cnt <= '0; good_lines <= '0; frame_ok <= 1'b0;
      rep <= '0; row <= '0; col <= '0; pix_k <= '0; shreg <= '0;
    end else if (pix_en) begin
      hs_r  <= hsync_in;
      hs_d  <= hs_r;
      vs_r  <= vsync_in;
      vs_d  <= vs_r;
      vid_r <= vid_in;
      h_pos <= hfall ? 10'd1 : sat_inc(h_pos);
      if (vfall)      v_cnt <= {9'd0, hfall};
      else if (hfall) v_cnt <= sat_inc(v_cnt);
      if (hfall) begin
        good_lines <= line_bad ? 2'd0 : ((good_lines == 2'd2) ? 2'd2 : good_lines + 2'd1);
        pix_k <= '0;
        col   <= '0;
        if (next_line == V_BEGIN) begin
          rep <= '0;
          row <= '0;
        end else if (rep == LAST_REP) begin
          rep <= '0;
          row <= row + 8'd1;
        end else begin
          rep <= rep + 2'd1;
        end
      end else if (sample_px) begin
        shreg <= {shreg[3:0], vid_r};
        if (pix_k == LAST_PIX) begin
          pix_k <= '0;
          col   <= col + 6'd1;
        end else begin
          pix_k <= pix_k + 3'd1;
        end
      end
      if (line_bad)   frame_ok <= 1'b0;
      else if (vfall) frame_ok <= !frame_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n)                       locked <= 1'b0;
    else if (line_bad || frame_bad)    locked <= 1'b0;
    else if (good_lines == 2'd2 && frame_ok) locked <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state    <= IDLE;
      cap_done <= 1'b0;
      cap_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      cap_done <= done_nx;
      if (clr_err)      cap_err <= 1'b0;
      else if (set_err) cap_err <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    set_err  = 1'b0;
    clr_err  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (cap_arm) begin
          if (locked) begin
            state_nx = ARMED;
            clr_err  = 1'b1;
          end else begin
            set_err = 1'b1;
          end
        end
      end
      ARMED: begin
        if (!locked) begin
          state_nx = IDLE;
          set_err  = 1'b1;
        end else if (vfall) begin
          state_nx = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!locked) begin
          state_nx = IDLE;
          set_err  = 1'b1;
        end else if (last_write) begin
          state_nx = DONE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  capture_ram #(.AW(14), .DW(6)) u_ram (
    .clk      (clk),
    .srst_n   (srst_n),
    .wr_en    (wr_en),
    .wr_addr  ({row, col}),
    .wr_data  ({shreg, vid_r}),
    .rd_en    (rd_req),
    .rd_addr  ({rd_y, rd_x}),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

endmodule

// File: tb/tb_vga_capture.sv
// tb/tb_vga_capture.sv - randomized frame stimulus against an image-level capture model
module tb_vga_capture;
  import vga_capture_pkg::*;

  localparam int LT  = 40;
  localparam int FT  = 44;
  localparam int HS  = 8;
  localparam int VS  = 4;
  localparam int NC  = 4;
  localparam int NR  = 12;
  localparam int HSW = 4;

  logic       clk = 1'b0;
  logic       srst_n, pix_en, vid_in, hsync_in, vsync_in, cap_arm, rd_req;
  logic [7:0] rd_y;
  logic [5:0] rd_x;
  logic [5:0] rd_data;
  logic       rd_valid, locked, cap_busy, cap_done, cap_err;

  always #5 clk = ~clk;

  vga_capture #(
    .H_START(HS), .V_START(VS), .LINE_TOTAL(LT), .FRAME_TOTAL(FT), .COLS(NC), .ROWS(NR)
  ) dut (
    .clk(clk), .srst_n(srst_n), .pix_en(pix_en), .vid_in(vid_in), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .cap_arm(cap_arm), .rd_req(rd_req), .rd_y(rd_y), .rd_x(rd_x),
    .rd_data(rd_data), .rd_valid(rd_valid), .locked(locked), .cap_busy(cap_busy),
    .cap_done(cap_done), .cap_err(cap_err)
  );

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  logic       img [0:FT-1][0:LT-1];
  logic [5:0] exp_mem [0:NR-1][0:NC-1];

  always @(negedge clk) if (cap_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_img(input int mode);
    for (int y = 0; y < FT; y++)
      for (int x = 0; x < LT; x++)
        img[y][x] = (mode == 2) ? (y == VS + 3 * 10 + 1) : 1'($urandom_range(0, 1));
    if (mode == 1)
      for (int r = 0; r < NR; r++)
        for (int i = 0; i < 6; i++)
          img[VS + 3 * r + 1][HS + i] = (i % 2 == 0);
  endtask

  function automatic logic [5:0] model_word(input int r, input int c);
    logic [5:0] w = '0;
    for (int i = 0; i < 6; i++) w[5 - i] = img[VS + 3 * r + 1][HS + 6 * c + i];
    return w;
  endfunction

  task automatic commit_rows(input int upto_line);
    for (int r = 0; r < NR; r++)
      if (VS + 3 * r + 1 < upto_line)
        for (int c = 0; c < NC; c++) exp_mem[r][c] = model_word(r, c);
  endtask

  task automatic tick(input logic h, input logic v, input logic d);
    if ($urandom_range(0, 3) == 0) begin
      pix_en   = 1'b0;
      vid_in   = 1'($urandom_range(0, 1));
      hsync_in = 1'($urandom_range(0, 1));
      vsync_in = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    pix_en = 1'b1; hsync_in = h; vsync_in = v; vid_in = d;
    @(posedge clk); #1;
    pix_en = 1'b0;
  endtask

  task automatic arm_pulse();
    cap_arm = 1'b1;
    @(posedge clk); #1;
    cap_arm = 1'b0;
  endtask

  task automatic drive_frame(input int arm_a, input int arm_b, input int cut_line, input int stop_line);
    for (int y = 0; y < FT; y++) begin
      int len;
      if (y == stop_line) return;
      if (y == arm_a || y == arm_b) arm_pulse();
      len = (y == cut_line) ? LT - 1 : LT;
      for (int x = 0; x < len; x++) tick(x >= len - HSW, y >= FT - 2, img[y][x]);
    end
  endtask

  task automatic read_check(input int y, input int x, input logic [5:0] exp);
    rd_y = 8'(y); rd_x = 6'(x); rd_req = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(negedge clk);
    chk($sformatf("rd_early_valid_y%0d_x%0d", y, x), rd_valid, 1'b0);
    @(negedge clk);
    chk($sformatf("rd_valid_y%0d_x%0d", y, x), rd_valid, 1'b1);
    chk($sformatf("rd_data_y%0d_x%0d", y, x), rd_data, exp);
    @(posedge clk); #1;
  endtask

  task automatic read_all();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) read_check(r, c, exp_mem[r][c]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    srst_n = 1'b0; pix_en = 1'b0; vid_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    cap_arm = 1'b0; rd_req = 1'b0; rd_y = '0; rd_x = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_locked", locked, 1'b0);
    chk("rst_busy", cap_busy, 1'b0);
    chk("rst_done", cap_done, 1'b0);
    chk("rst_err", cap_err, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 6'h00);
    chk("rst_state", dut.state, IDLE);
    @(posedge clk); #1;
    srst_n = 1'b1;
    repeat (4) tick(1'b1, 1'b1, 1'b0);

    // frame 1: not yet locked, arming must be refused
    fill_img(0);
    drive_frame(5, -1, -1, FT);
    @(negedge clk);
    chk("f1_err", cap_err, 1'b1);
    chk("f1_busy", cap_busy, 1'b0);
    chk("f1_locked", locked, 1'b0);
    @(posedge clk); #1;

    fill_img(0);
    drive_frame(5, -1, -1, FT);
    @(negedge clk);
    chk("f2_locked", locked, 1'b1);
    chk("f2_busy", cap_busy, 1'b1);
    chk("f2_err", cap_err, 1'b0);
    chk("f2_state", dut.state, ARMED);
    @(posedge clk); #1;

    // pattern capture; extra arm mid-capture is ignored, arm after DONE re-arms
    fill_img(1);
    drive_frame(20, 42, -1, FT);
    commit_rows(FT);
    @(negedge clk);
    chk("f3_done_cnt", done_cnt, 1);
    chk("f3_busy", cap_busy, 1'b1);
    chk("f3_err", cap_err, 1'b0);
    @(posedge clk); #1;
    read_check(5, 0, 6'h2A);
    @(negedge clk);
    chk("rd_valid_single", rd_valid, 1'b0);
    repeat (4) @(negedge clk);
    chk("rd_data_hold", rd_data, 6'h2A);
    @(posedge clk); #1;
    read_all();

    fill_img(2);
    drive_frame(-1, 42, -1, FT);
    commit_rows(FT);
    @(negedge clk);
    chk("f4_done_cnt", done_cnt, 2);
    @(posedge clk); #1;
    for (int c = 0; c < NC; c++) begin
      read_check(10, c, 6'h3F);
      read_check(9, c, 6'h00);
      read_check(11, c, 6'h00);
    end

    // short line mid-capture drops lock and aborts
    fill_img(0);
    drive_frame(-1, -1, 20, FT);
    @(negedge clk);
    chk("f5_locked", locked, 1'b0);
    chk("f5_busy", cap_busy, 1'b0);
    chk("f5_state", dut.state, IDLE);
    chk("f5_err", cap_err, 1'b1);
    chk("f5_done_cnt", done_cnt, 2);
    @(posedge clk); #1;

    fill_img(0);
    drive_frame(5, -1, -1, FT);
    @(negedge clk);
    chk("f6_locked", locked, 1'b1);
    chk("f6_busy", cap_busy, 1'b1);
    chk("f6_err", cap_err, 1'b0);
    @(posedge clk); #1;

    fill_img(0);
    drive_frame(-1, 42, -1, FT);
    commit_rows(FT);
    @(negedge clk);
    chk("f7_done_cnt", done_cnt, 3);
    @(posedge clk); #1;
    read_all();

    // reset in the middle of a capture
    fill_img(0);
    drive_frame(-1, -1, -1, 20);
    @(negedge clk);
    chk("f8_state", dut.state, CAPTURE);
    @(posedge clk); #1;
    srst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_state", dut.state, IDLE);
    chk("mrst_locked", locked, 1'b0);
    chk("mrst_busy", cap_busy, 1'b0);
    chk("mrst_done", cap_done, 1'b0);
    chk("mrst_err", cap_err, 1'b0);
    chk("mrst_rd_valid", rd_valid, 1'b0);
    chk("mrst_rd_data", rd_data, 6'h00);
    @(posedge clk); #1;
    srst_n = 1'b1;
    commit_rows(20);
    read_all();
    @(negedge clk);
    chk("final_done_cnt", done_cnt, 3);
    chk("final_err", cap_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
